// File: rtl/uart_rx_ctrl.sv
// UART 8N1 receiver: 2-flop synchroniser, centre-sampling baud timer, frame FSM.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err strobe.
module uart_rx_ctrl #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int DIV  = CLK_FREQ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_BIT  = CW'(DIV - 1);

  if (DIV < 4) begin : g_div_check
    $error("uart_rx_ctrl: CLK_FREQ/BAUD must be at least 4");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    shift;
  logic          rx_m;
  logic          rxs;

  // Synchroniser resets to the idle line level so reset release cannot fake a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rxs  <= 1'b1;
    end else begin
      rx_m <= rx;
      rxs  <= rx_m;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic perr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bitn       <= 3'd0;
      shift      <= 8'h00;
      data       <= 8'h00;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
      perr       <= 1'b0;
    end else begin
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rxs) begin
              state <= DATA;
              bitn  <= 3'd0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_BIT) begin
            cnt   <= '0;
            shift <= {rxs, shift[7:1]};
            bitn  <= bitn + 3'd1;
            if (bitn == 3'd7) state <= PARITY;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (cnt == CNT_BIT) begin
            cnt   <= '0;
            perr  <= rxs ^ (^shift);
            state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_BIT) begin
            cnt <= '0;
            if (rxs) begin
              state <= IDLE;
              busy  <= 1'b0;
              if (perr) begin
                parity_err <= 1'b1;
              end else begin
                data  <= shift;
                valid <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rxs) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end
`else
  assign parity_err = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bitn      <= 3'd0;
      shift     <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rxs) begin
              state <= DATA;
              bitn  <= 3'd0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_BIT) begin
            cnt   <= '0;
            shift <= {rxs, shift[7:1]};
            bitn  <= bitn + 3'd1;
            if (bitn == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
          if (cnt == CNT_BIT) begin
            cnt <= '0;
            if (rxs) begin
              state <= IDLE;
              busy  <= 1'b0;
              data  <= shift;
              valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rxs) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios plus random frames, checked every
// cycle against a frame-level event schedule (which cycle must carry which strobe).
module tb_uart_rx_ctrl;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int DIV      = 10;
  localparam int HALF     = 5;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS    = 11;
  localparam int LAT      = 2 + HALF + 10 * DIV;
  localparam int LAT_LIT  = 107;
  localparam int GAP_LIT  = 110;
`else
  localparam int NBITS    = 10;
  localparam int LAT      = 2 + HALF + 9 * DIV;
  localparam int LAT_LIT  = 97;
  localparam int GAP_LIT  = 100;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  uart_rx_ctrl #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (cyc > 40000) begin
      $display("FAIL watchdog: cycle %0d exceeded budget 40000", cyc);
      $fatal(1);
    end
  end

  int         n_cmp = 0;
  int         n_bad = 0;
  int         exp_kind[int];
  logic [7:0] exp_byte[int];
  logic [7:0] data_model = 8'h00;
  logic       busy_h[int];
  int         vq[$];
  int         fq[$];
  int         pq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Per-cycle compare: kind 1 = valid, 2 = frame_err, 3 = parity_err.
  always begin : compare
    int k;
    @(negedge clk);
    #1;
    busy_h[cyc] = busy;
    if (valid)      vq.push_back(cyc);
    if (frame_err)  fq.push_back(cyc);
    if (parity_err) pq.push_back(cyc);
    if (rst) data_model = 8'h00;
    k = exp_kind.exists(cyc) ? exp_kind[cyc] : 0;
    if (k == 1) data_model = exp_byte[cyc];
    check("valid",      valid,      k == 1);
    check("frame_err",  frame_err,  k == 2);
    check("parity_err", parity_err, k == 3);
    check("data",       data,       data_model);
  end

  task automatic idle(input int n);
    repeat (n) begin
      rx = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic hold_low(input int n);
    repeat (n) begin
      rx = 1'b0;
      @(negedge clk);
    end
  endtask

  // Called at a negedge; p is the clock edge that first sees the start bit on rx.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic pflip,
                            output int p);
    logic [NBITS-1:0] f;
    int               kind;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef UART_RX_PARITY_EN
    f[9]   = (^b) ^ pflip;
    f[10]  = stop;
`else
    f[9]   = stop;
`endif
    kind = !stop ? 2 : (pflip ? 3 : 1);
    p = cyc + 1;
    exp_kind[p + LAT] = kind;
    exp_byte[p + LAT] = b;
    for (int i = 0; i < NBITS; i++) begin
      rx = f[i];
      repeat (DIV) @(negedge clk);
    end
  endtask

  task automatic glitch(input int len, output int p);
    p = cyc + 1;
    hold_low(len);
  endtask

  initial begin : stim
    int         p, p2, nb;
    logic [7:0] ab;
    logic [7:0] rb;
    int         r;
    logic       pf;

    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    idle(50);
    check("idle_busy", busy, 1'b0);
    check("idle_data", data, 8'h00);
    check("idle_strobes", vq.size() + fq.size() + pq.size(), 0);

    // Single frame 0xA5
    send_frame(8'hA5, 1'b1, 1'b0, p);
    idle(20);
    check("a5_count", vq.size(), 1);
    if (vq.size() == 1) check("a5_latency", vq[0] - p, LAT_LIT);
    check("a5_data", data, 8'hA5);
    check("a5_busy_before", busy_h[p + LAT_LIT - 1], 1'b1);
    check("a5_busy_fall", busy_h[p + LAT_LIT], 1'b0);
    vq.delete();

    // Back-to-back 0x3C, 0xC3
    send_frame(8'h3C, 1'b1, 1'b0, p);
    send_frame(8'hC3, 1'b1, 1'b0, p2);
    idle(20);
    check("b2b_count", vq.size(), 2);
    if (vq.size() == 2) check("b2b_spacing", vq[1] - vq[0], GAP_LIT);
    check("b2b_data", data, 8'hC3);
    vq.delete();

    // 3-cycle glitch
    glitch(3, p);
    idle(20);
    nb = 0;
    for (int i = 0; i < 20; i++) if (busy_h[p + i] === 1'b1) nb++;
    check("glitch_busy_cycles", nb, 5);
    check("glitch_strobes", vq.size() + fq.size() + pq.size(), 0);
    check("glitch_data", data, 8'hC3);

    // Framing error then break
    send_frame(8'h55, 1'b0, 1'b0, p);
    hold_low(200);
    check("break_busy", busy_h[p + 150], 1'b1);
    idle(20);
    check("ferr_count", fq.size(), 1);
    if (fq.size() == 1) check("ferr_latency", fq[0] - p, LAT_LIT);
    check("ferr_valid_none", vq.size(), 0);
    check("ferr_data_kept", data, 8'hC3);
    send_frame(8'h0F, 1'b1, 1'b0, p);
    idle(20);
    check("after_break_data", data, 8'h0F);
    check("after_break_count", vq.size(), 1);
    vq.delete();
    fq.delete();

    // Reset at bit 4 of a frame
    ab = 8'h81;
    hold_low(DIV);
    for (int i = 0; i < 4; i++) begin
      rx = ab[i];
      repeat (DIV) @(negedge clk);
    end
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(30);
    check("abort_strobes", vq.size() + fq.size() + pq.size(), 0);
    check("abort_data", data, 8'h00);
    send_frame(8'h81, 1'b1, 1'b0, p);
    idle(20);
    check("post_reset_data", data, 8'h81);
`ifdef UART_RX_PARITY_EN
    send_frame(8'h81, 1'b1, 1'b1, p);
    idle(20);
    check("perr_count", pq.size(), 1);
    check("perr_data_kept", data, 8'h81);
`endif
    vq.delete();
    fq.delete();
    pq.delete();

    // Random mix of good frames, glitches and bad stop bits
    for (int n = 0; n < 40; n++) begin
      r  = $urandom_range(0, 9);
      rb = 8'($urandom_range(0, 255));
`ifdef UART_RX_PARITY_EN
      pf = ($urandom_range(0, 3) == 0);
`else
      pf = 1'b0;
`endif
      if (r == 0) begin
        glitch($urandom_range(1, 3), p);
        idle(12);
      end else if (r == 1) begin
        send_frame(rb, 1'b0, pf, p);
        idle(5 + $urandom_range(0, 10));
      end else begin
        send_frame(rb, 1'b1, pf, p);
        idle($urandom_range(0, 6));
      end
    end
    idle(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
